// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer that shares one single-port memory between port 0 and port 1.
// Read ack lands 2 cycles after mem_resp and write ack 1 cycle after. A request stays pending while its req is held.
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_i,
  input  logic                  p0_we_i,
  input  logic [ADDR_WIDTH-1:0] p0_addr_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  output logic                  p0_ack_o,
  output logic                  p0_err_o,
  input  logic                  p1_req_i,
  input  logic                  p1_we_i,
  input  logic [ADDR_WIDTH-1:0] p1_addr_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic                  p1_ack_o,
  output logic                  p1_err_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_resp_i
);

  typedef enum logic [1:0] {IDLE, BUSY, CAPTURE, ACK} state_e;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  gnt_q, gnt_d;
  logic                  last_q, last_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rd0_q, rd0_d;
  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  sel;

  // On a tie the port not granted last wins; otherwise whichever port asks.
  assign sel = (p0_req_i && p1_req_i) ? ~last_q : p1_req_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    case (state_q)
      IDLE: begin
        if (p0_req_i || p1_req_i) begin
          gnt_d   = sel;
          last_d  = sel;
          we_d    = sel ? p1_we_i    : p0_we_i;
          addr_d  = sel ? p1_addr_i  : p0_addr_i;
          wdata_d = sel ? p1_wdata_i : p0_wdata_i;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_resp_i) begin
          state_d = we_q ? ACK : CAPTURE;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          // Clear here so the port already sees zero data in its ack/err cycle.
          err_d   = 1'b1;
          state_d = ACK;
          if (gnt_q) rd1_d = '0;
          else       rd0_d = '0;
        end
      end
      CAPTURE: begin
        if (gnt_q) rd1_d = mem_rdata_i;
        else       rd0_d = mem_rdata_i;
        state_d = ACK;
      end
      ACK: begin
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_read_o  = (state_q == BUSY) && !we_q;
  assign mem_write_o = (state_q == BUSY) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign p0_ack_o   = (state_q == ACK) && !gnt_q;
  assign p1_ack_o   = (state_q == ACK) && gnt_q;
  assign p0_err_o   = p0_ack_o && err_q;
  assign p1_err_o   = p1_ack_o && err_q;
  assign p0_rdata_o = rd0_q;
  assign p1_rdata_o = rd1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small delay-D memory model behind it.
module tb_mem_port_arbiter;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_ack, p0_err, p1_ack, p1_err;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_resp;
  logic        stray_resp, resp_en, load_mem;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_rdata_o(p0_rdata), .p0_ack_o(p0_ack), .p0_err_o(p0_err),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_rdata_o(p1_rdata), .p1_ack_o(p1_ack), .p1_err_o(p1_err),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .mem_resp_i(mem_resp)
  );

  // Memory model: resp D+1 cycles after the strobe rises, read data the cycle after resp.
  logic [31:0] mem [0:15];
  int          mcnt;
  logic        m_resp, prev_s;
  logic        strobe;
  assign strobe   = mem_read | mem_write;
  assign mem_resp = m_resp | stray_resp;

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 0) ? 32'h0000_0013 : 32'h0;
    end
    if (!rst_n) begin
      mcnt   <= 0;
      m_resp <= 1'b0;
      prev_s <= 1'b0;
    end else begin
      prev_s <= strobe;
      m_resp <= 1'b0;
      if (strobe && !prev_s) mcnt <= D;
      else if (mcnt != 0) begin
        mcnt <= mcnt - 1;
        if (mcnt == 1 && resp_en) begin
          m_resp <= 1'b1;
          if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
        end
      end
    end
    mem_rdata <= m_resp ? mem[mem_addr[5:2]] : 32'hBAD0_BAD0;
  end

  // Protocol monitor.
  int both_hi = 0, short_gap = 0, low_run = 0, p0_acks = 0, p1_acks = 0, strobe_cycles = 0;
  logic seen = 1'b0;
  always @(negedge clk) begin
    if (mem_read && mem_write) both_hi++;
    if (p0_ack) p0_acks++;
    if (p1_ack) p1_acks++;
    if (!rst_n) begin
      seen    = 1'b0;
      low_run = 0;
    end else if (strobe) begin
      strobe_cycles++;
      if (seen && low_run > 0 && low_run < 2) short_gap++;
      low_run = 0;
      seen    = 1'b1;
    end else begin
      low_run++;
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    else n_pass++;
  endtask

  // One transaction; k counts cycles after the IDLE cycle in which req is first seen.
  task automatic run_txn(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int ack_k, output int str_cnt,
                         output int first_k, output int resp_k, output logic err,
                         output logic other_ack);
    ack_k = 0; str_cnt = 0; first_k = 0; resp_k = 0; err = 1'b0; other_ack = 1'b0;
    @(negedge clk);
    if (port == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (strobe) begin
        str_cnt++;
        if (first_k == 0) first_k = k;
      end
      if (mem_resp) resp_k = k;
      if ((port == 0) ? p1_ack : p0_ack) other_ack = 1'b1;
      if ((port == 0) ? p0_ack : p1_ack) begin
        ack_k  = k;
        err    = (port == 0) ? p0_err : p1_err;
        p0_req = 1'b0;
        p1_req = 1'b0;
        break;
      end
    end
    if (ack_k == 0) begin
      p0_req = 1'b0;
      p1_req = 1'b0;
    end
    chk("txn_completed", ack_k != 0, 1'b1);
  endtask

  int   ack_k, str_cnt, first_k, resp_k, nacks, a0, a1, s0;
  logic err, other;
  int   ord [4];
  int   ackk [4];

  initial begin
    load_mem = 1'b1; rst_n = 1'b0; resp_en = 1'b1; stray_resp = 1'b0;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("rst_ack_err", {p0_ack, p1_ack, p0_err, p1_err}, 4'b0000);
    chk("rst_addr_wdata", {mem_addr, mem_wdata}, 64'h0);
    chk("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
    load_mem = 1'b0;
    rst_n    = 1'b1;
    @(negedge clk);

    // Single read from port 0.
    run_txn(0, 1'b0, 32'h0, 32'h0, ack_k, str_cnt, first_k, resp_k, err, other);
    chk("rd_first_strobe", first_k, 1);
    chk("rd_strobe_cycles", str_cnt, 4);
    chk("rd_resp_cycle", resp_k, 4);
    chk("rd_ack_cycle", ack_k, 6);
    chk("rd_err", err, 1'b0);
    chk("rd_other_ack", other, 1'b0);
    chk("rd_p0_rdata", p0_rdata, 32'h0000_0013);

    // Port 1 write then read back.
    run_txn(1, 1'b1, 32'h8, 32'hDEAD_BEEF, ack_k, str_cnt, first_k, resp_k, err, other);
    chk("wr_resp_cycle", resp_k, 4);
    chk("wr_ack_cycle", ack_k, 5);
    chk("wr_other_ack", other, 1'b0);
    run_txn(1, 1'b0, 32'h8, 32'h0, ack_k, str_cnt, first_k, resp_k, err, other);
    chk("rb_ack_cycle", ack_k, 6);
    chk("rb_p1_rdata", p1_rdata, 32'hDEAD_BEEF);
    chk("rb_p0_rdata_kept", p0_rdata, 32'h0000_0013);

    // Contention: both requests held from reset.
    @(negedge clk);
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h8;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nacks = 0;
    for (int k = 1; k <= 100 && nacks < 4; k++) begin
      @(negedge clk);
      if (p0_ack || p1_ack) begin
        ord[nacks]  = p1_ack ? 1 : 0;
        ackk[nacks] = k;
        nacks++;
        if (nacks == 4) begin
          p0_req = 1'b0;
          p1_req = 1'b0;
        end
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    chk("cont_nacks", nacks, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("cont_grant%0d", i), ord[i], i % 2);
    for (int i = 1; i < 4; i++) chk($sformatf("cont_spacing%0d", i), ackk[i] - ackk[i-1], D + 5);
    chk("cont_p0_rdata", p0_rdata, 32'h0000_0013);
    chk("cont_p1_rdata", p1_rdata, 32'hDEAD_BEEF);

    // Timeout: memory never responds.
    resp_en = 1'b0;
    run_txn(0, 1'b0, 32'h4, 32'h0, ack_k, str_cnt, first_k, resp_k, err, other);
    chk("to_ack_cycle", ack_k, 9);
    chk("to_err", err, 1'b1);
    chk("to_strobe_cycles", str_cnt, 8);
    chk("to_p0_rdata", p0_rdata, 32'h0);
    chk("to_p1_rdata_kept", p1_rdata, 32'hDEAD_BEEF);
    resp_en = 1'b1;
    run_txn(0, 1'b0, 32'h0, 32'h0, ack_k, str_cnt, first_k, resp_k, err, other);
    chk("post_to_ack_cycle", ack_k, 6);
    chk("post_to_err", err, 1'b0);
    chk("post_to_rdata", p0_rdata, 32'h0000_0013);

    // Reset in the middle of BUSY.
    @(negedge clk);
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h8;
    repeat (2) @(negedge clk);
    chk("mid_busy_read", mem_read, 1'b1);
    rst_n  = 1'b0;
    p1_req = 1'b0;
    a0 = p0_acks; a1 = p1_acks;
    @(negedge clk);
    chk("mid_rst_strobes", {mem_read, mem_write}, 2'b00);
    chk("mid_rst_ack", {p0_ack, p1_ack, p0_err, p1_err}, 4'b0000);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("mid_rst_no_ack", (p0_acks - a0) + (p1_acks - a1), 0);
    run_txn(1, 1'b0, 32'h8, 32'h0, ack_k, str_cnt, first_k, resp_k, err, other);
    chk("mid_rst_read_ack", ack_k, 6);
    chk("mid_rst_read_data", p1_rdata, 32'hDEAD_BEEF);

    // Stray response while idle.
    @(negedge clk);
    a0 = p0_acks; a1 = p1_acks; s0 = strobe_cycles;
    stray_resp = 1'b1;
    @(negedge clk);
    stray_resp = 1'b0;
    repeat (5) @(negedge clk);
    chk("stray_no_ack", (p0_acks - a0) + (p1_acks - a1), 0);
    chk("stray_no_strobe", strobe_cycles - s0, 0);
    run_txn(0, 1'b0, 32'h0, 32'h0, ack_k, str_cnt, first_k, resp_k, err, other);
    chk("stray_then_read_ack", ack_k, 6);

    chk("never_both_strobes", both_hi, 0);
    chk("strobe_gap_min2", short_gap, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
